rotary_encoder: RTL and testbench



---
 rtl/rotary_encoder.sv | 130 +++++++++++++
 tb/tb_rotary_encoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_encoder.sv
// rtl/rotary_encoder.sv - quadrature rotary encoder front end producing a pwm level
module rotary_encoder #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int STEP            = 1,
  parameter int SATURATE        = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic [WIDTH-1:0] value,
  output logic             step_up,
  output logic             step_down
);

  // Debounce counters only ever hold 0..DEBOUNCE_CYCLES-1; the settle counter holds 0..DEBOUNCE_CYCLES+1.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SET_W = $clog2(DEBOUNCE_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(DEBOUNCE_CYCLES + 1);
  localparam logic [WIDTH:0]   STEP_EXT = (WIDTH + 1)'(STEP);

  typedef enum logic {INIT, RUN} state_t;

  state_t           state;
  logic [SET_W-1:0] settle;
  logic             a_s1, a_s2, b_s1, b_s2;
  logic             a_deb, b_deb, a_prev, b_prev;
  logic [CNT_W-1:0] a_cnt, b_cnt;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] up_val, dn_val;

  // Two-flop synchronisers bring the raw asynchronous lines into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
    end else begin
      a_s1 <= a;
      a_s2 <= a_s1;
      b_s1 <= b;
      b_s2 <= b_s1;
    end
  end

  // Next value one step up or down, with the carry/borrow bit kept to detect wrap.
  always_comb begin
    sum_ext  = {1'b0, value} + STEP_EXT;
    diff_ext = {1'b0, value} - STEP_EXT;
    up_val   = sum_ext[WIDTH-1:0];
    dn_val   = diff_ext[WIDTH-1:0];
    if ((SATURATE != 0) && sum_ext[WIDTH]) begin
      up_val = '1;
    end
    if ((SATURATE != 0) && diff_ext[WIDTH]) begin
      dn_val = '0;
    end
  end

  // Settle FSM, per-channel debounce and registered direction decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= INIT;
      settle    <= '0;
      a_deb     <= 1'b0;
      b_deb     <= 1'b0;
      a_prev    <= 1'b0;
      b_prev    <= 1'b0;
      a_cnt     <= '0;
      b_cnt     <= '0;
      value     <= '0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
    end else begin
      step_up   <= 1'b0;
      step_down <= 1'b0;
      case (state)
        INIT: begin
          // Absorb the resting encoder levels so the first RUN cycle sees no change.
          a_deb  <= a_s2;
          b_deb  <= b_s2;
          a_prev <= a_s2;
          b_prev <= b_s2;
          a_cnt  <= '0;
          b_cnt  <= '0;
          if (settle == SET_LAST) begin
            state <= RUN;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        RUN: begin
          if (a_s2 == a_deb) begin
            a_cnt <= '0;
          end else if (a_cnt == CNT_LAST) begin
            a_deb <= a_s2;
            a_cnt <= '0;
          end else begin
            a_cnt <= a_cnt + 1'b1;
          end
          if (b_s2 == b_deb) begin
            b_cnt <= '0;
          end else if (b_cnt == CNT_LAST) begin
            b_deb <= b_s2;
            b_cnt <= '0;
          end else begin
            b_cnt <= b_cnt + 1'b1;
          end
          a_prev <= a_deb;
          b_prev <= b_deb;
          // Only an A edge with B steady is a detent; A and B together is a skipped state.
          if ((a_deb != a_prev) && (b_deb == b_prev)) begin
            if (a_deb != b_deb) begin
              value   <= up_val;
              step_up <= 1'b1;
            end else begin
              value     <= dn_val;
              step_down <= 1'b1;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rotary_encoder.sv
// tb/tb_rotary_encoder.sv - directed self-checking bench for rotary_encoder
module tb_rotary_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic [7:0] v0, v1;
  logic [1:0] v2;
  logic       u0, d0, u1, d1, u2, d2;

  int compared = 0;
  int mismatched = 0;
  int e0 = 0, e1 = 0, e2 = 0;
  logic qa = 1'b0, qb = 1'b0;
  int up0 = 0, dn0 = 0;
  int snap_up, snap_dn;

  rotary_encoder #(.WIDTH(8), .DEBOUNCE_CYCLES(8), .STEP(1), .SATURATE(0)) dut0 (
    .clk(clk), .reset(reset), .a(a), .b(b), .value(v0), .step_up(u0), .step_down(d0));
  rotary_encoder #(.WIDTH(8), .DEBOUNCE_CYCLES(8), .STEP(1), .SATURATE(1)) dut1 (
    .clk(clk), .reset(reset), .a(a), .b(b), .value(v1), .step_up(u1), .step_down(d1));
  rotary_encoder #(.WIDTH(2), .DEBOUNCE_CYCLES(8), .STEP(1), .SATURATE(1)) dut2 (
    .clk(clk), .reset(reset), .a(a), .b(b), .value(v2), .step_up(u2), .step_down(d2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Pulse counting and the never-both-high rule, sampled between clock edges.
  always @(negedge clk) begin
    if (u0 === 1'b1) up0++;
    if (d0 === 1'b1) dn0++;
    if (!reset) begin
      chk("both_high0", {31'b0, u0 & d0}, 0);
      chk("both_high1", {31'b0, u1 & d1}, 0);
    end
  end

  task automatic chk_vals(input string tag);
    chk({tag, "_v0"}, {24'b0, v0}, e0);
    chk({tag, "_v1"}, {24'b0, v1}, e1);
    chk({tag, "_v2"}, {30'b0, v2}, e2);
  endtask

  task automatic chk_pulses(input string tag, input logic eu, input logic ed);
    chk({tag, "_up0"}, {31'b0, u0}, {31'b0, eu});
    chk({tag, "_dn0"}, {31'b0, d0}, {31'b0, ed});
    chk({tag, "_up1"}, {31'b0, u1}, {31'b0, eu});
    chk({tag, "_dn1"}, {31'b0, d1}, {31'b0, ed});
    chk({tag, "_up2"}, {31'b0, u2}, {31'b0, eu});
    chk({tag, "_dn2"}, {31'b0, d2}, {31'b0, ed});
  endtask

  // dir: 0 none, 1 up, 2 down; e0 wraps at 8 bits, e1 clamps at 8 bits, e2 clamps at 2 bits.
  task automatic model_step(input int dir);
    if (dir == 1) begin
      e0 = (e0 + 1) % 256;
      e1 = (e1 == 255) ? 255 : e1 + 1;
      e2 = (e2 == 3) ? 3 : e2 + 1;
    end else if (dir == 2) begin
      e0 = (e0 + 255) % 256;
      e1 = (e1 == 0) ? 0 : e1 - 1;
      e2 = (e2 == 0) ? 0 : e2 - 1;
    end
  endtask

  // Clean transition driven at a negedge; next posedge is N, result lands at N+10.
  task automatic xfer(input logic na, input logic nb, input int dir);
    a = na;
    b = nb;
    repeat (10) @(negedge clk);
    chk_vals("pre");
    chk_pulses("pre", 1'b0, 1'b0);
    model_step(dir);
    @(negedge clk);
    chk_vals("upd");
    chk_pulses("upd", dir == 1, dir == 2);
    @(negedge clk);
    chk_vals("post");
    chk_pulses("post", 1'b0, 1'b0);
    qa = na;
    qb = nb;
  endtask

  task automatic cw();
    if (qa == qb) xfer(~qa, qb, 1);
    else          xfer(qa, ~qb, 0);
  endtask

  task automatic ccw();
    if (qa == qb) xfer(qa, ~qb, 0);
    else          xfer(~qa, qb, 2);
  endtask

  task automatic cw_detent();
    if (qa != qb) cw();
    cw();
  endtask

  task automatic ccw_detent();
    if (qa == qb) ccw();
    ccw();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    e0 = 0; e1 = 0; e2 = 0;
    chk_vals("rst");
    chk_pulses("rst", 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    // Test 1: reset with a=b=0, then one clean CW detent with exact latency.
    do_reset(3);
    repeat (12) @(negedge clk);
    xfer(1'b1, 1'b0, 1);

    // Test 4: underflow wrap vs clamp at 0, then 255+1 wrap; 2-bit instance clamps at 3.
    ccw_detent();
    ccw_detent();
    chk("wrap_down_v0", {24'b0, v0}, 255);
    chk("clamp_low_v1", {24'b0, v1}, 0);
    cw_detent();
    chk("wrap_up_v0", {24'b0, v0}, 0);
    cw_detent();
    cw_detent();
    cw_detent();
    chk("clamp_high_v2", {30'b0, v2}, 3);

    // Test 3: 3-cycle bursts on a then settle high with b=0 gives exactly one step.
    ccw_detent();
    snap_up = up0;
    snap_dn = dn0;
    for (int i = 0; i < 20; i++) begin
      a = ((i / 3) % 2 == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    qa = 1'b1;
    model_step(1);
    chk("bounce_ups", up0 - snap_up, 1);
    chk("bounce_dns", dn0 - snap_dn, 0);
    chk_vals("bounce");

    // 7-cycle glitch is rejected; 8-cycle glitch is accepted (down then back up).
    snap_up = up0;
    snap_dn = dn0;
    a = 1'b0;
    repeat (7) @(negedge clk);
    a = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch7_ups", up0 - snap_up, 0);
    chk("glitch7_dns", dn0 - snap_dn, 0);
    chk_vals("glitch7");
    a = 1'b0;
    repeat (8) @(negedge clk);
    a = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch8_ups", up0 - snap_up, 1);
    chk("glitch8_dns", dn0 - snap_dn, 1);
    chk_vals("glitch8");

    // Test 5: both lines change together -> no step; then a legal CCW detent.
    xfer(1'b0, 1'b1, 0);
    ccw_detent();

    // Test 2: a=b=1 held through reset release is absorbed by INIT.
    a = 1'b1;
    b = 1'b1;
    qa = 1'b1;
    qb = 1'b1;
    do_reset(2);
    snap_up = up0;
    snap_dn = dn0;
    repeat (100) @(negedge clk);
    chk("hold11_ups", up0 - snap_up, 0);
    chk("hold11_dns", dn0 - snap_dn, 0);
    chk_vals("hold11");

    // Test 6: climb to 37, start a debounce, reset mid-window.
    for (int g = 0; g < 300 && e0 != 37; g++) cw_detent();
    chk("reach37_v0", {24'b0, v0}, 37);
    a = ~qa;
    qa = ~qa;
    repeat (4) @(negedge clk);
    do_reset(1);
    snap_up = up0;
    snap_dn = dn0;
    repeat (30) @(negedge clk);
    chk("midrst_ups", up0 - snap_up, 0);
    chk("midrst_dns", dn0 - snap_dn, 0);
    chk_vals("midrst");

    // INIT length: edge first sampled at release+8 is absorbed, at release+9 it steps.
    do_reset(2);
    repeat (7) @(negedge clk);
    snap_up = up0;
    snap_dn = dn0;
    xfer(~qa, qb, 0);
    repeat (20) @(negedge clk);
    chk("init_edge8_ups", up0 - snap_up, 0);
    chk("init_edge8_dns", dn0 - snap_dn, 0);
    do_reset(2);
    repeat (8) @(negedge clk);
    xfer(~qa, qb, ((~qa) != qb) ? 1 : 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
